// File: rtl/regfile_sb.sv
// regfile_sb: parametrised MIPS register file with two combinational read
// ports, general + link write ports, syscall/return taps and a pending
// scoreboard for read-after-write hazard detection.
// Ports: clk/reset (sync, active-high); rd_addr/rd_data/rd_busy x2;
// wr_en/wr_addr/wr_data; link_en/link_data; claim_en/claim_addr;
// busy_count; taps v0/a0/ra.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int V0_REG   = 2,
  parameter int A0_REG   = 4,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   busy_count,
  output logic [DATA_W-1:0] v0,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] ra
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [ADDR_W:0]     r_cnt;

  logic                w_wr_hit;
  logic                w_link_hit;
  logic                w_claim_hit;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;

  assign w_wr_hit    = wr_en && (wr_addr != '0);
  assign w_link_hit  = link_en && (LINK_A != '0);
  assign w_claim_hit = claim_en && (claim_addr != '0);

  // Claim is applied after the write clears so a new producer wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_hit)
      w_pend_nxt[wr_addr] = 1'b0;
    if (w_link_hit)
      w_pend_nxt[LINK_A] = 1'b0;
    if (w_claim_hit)
      w_pend_nxt[claim_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + (ADDR_W + 1)'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      // Link is written last so it wins over the general port on ra.
      if (w_wr_hit)
        r_regs[wr_addr] <= wr_data;
      if (w_link_hit)
        r_regs[LINK_A] <= link_data;
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  function automatic logic [DATA_W-1:0] f_rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = r_regs[a];
    if (BYPASS) begin
      if (w_link_hit && a == LINK_A)
        v = link_data;
      else if (w_wr_hit && a == wr_addr)
        v = wr_data;
    end
    if (a == '0)
      v = '0;
    return v;
  endfunction

  // A same-cycle write retires the claim unless a fresh claim lands too.
  function automatic logic f_busy(
    input logic [ADDR_W-1:0] a
  );
    logic wr;
    logic cl;
    wr = (w_link_hit && a == LINK_A) ||
         (w_wr_hit && a == wr_addr);
    cl = w_claim_hit && a == claim_addr;
    if (BYPASS)
      return r_pend[a] && !(wr && !cl);
    return r_pend[a];
  endfunction

  assign rd_data1   = f_rd(rd_addr1);
  assign rd_data2   = f_rd(rd_addr2);
  assign rd_busy1   = f_busy(rd_addr1);
  assign rd_busy2   = f_busy(rd_addr2);
  assign busy_count = r_cnt;
  assign v0         = r_regs[V0_REG];
  assign a0         = r_regs[A0_REG];
  assign ra         = r_regs[LINK_REG];

endmodule
